hilo_div_ctrl: RTL and testbench
================================

// Module: hilo_div_ctrl
// PURPOSE
// - Sequences the multicycle unsigned divider (DIVU) and owns the HI/LO registers of the 5-stage CPU.
// - Runs a WIDTH-step restoring division, writes quotient to LO and remainder to HI, and stalls the
//   pipeline when a dependent MFHI/MFLO or a second DIVU reaches EX while a divide is in flight.
// - Drives the select of the EX-stage result mux (ALU / HI / LO).
// PARAMETERS
// - WIDTH     32     operand, HI and LO width
// - SEL_DIVU  2'b00  op code: divide
// - SEL_MFLO  2'b01  op code: move from LO
// - SEL_MFHI  2'b10  op code: move from HI
// - SEL_ALU   2'b11  op code: ordinary ALU result
// PORTS
// - clk        in   1      system clock, rising edge
// - rst_n      in   1      asynchronous active-low reset
// - ex_op      in   2      EX-stage op class (SEL_* codes)
// - ex_valid   in   1      EX holds a real instruction (0 = bubble)
// - dividend   in   WIDTH  DIVU rs operand
// - divisor    in   WIDTH  DIVU rt operand
// - hi         out  WIDTH  HI register (remainder)
// - lo         out  WIDTH  LO register (quotient)
// - res_sel    out  2      select to EX result mux
// - stall      out  1      freeze IF/ID/EX, insert bubble into MEM
// - busy       out  1      division in progress (state RUN)
// - div_done   out  1      one-cycle pulse, HI/LO just updated
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, hi=0, lo=0, count=0, work regs=0; busy=0, div_done=0.
//   Reset mid-division aborts it; HI/LO read 0 afterwards.
// - States: IDLE, RUN, DONE. start = ex_valid & ex_op==SEL_DIVU & ~stall.
//   IDLE/DONE --start--> RUN: latch divisor, Q<=dividend, R<=0, count<=0.
//   IDLE --no start--> IDLE; DONE --no start--> IDLE.
//   RUN: each edge one step: {R,Q} shifted left 1; if R_shifted >= divisor then R-=divisor, Q[0]=1.
//   RUN, count==WIDTH-1: step, write lo<=final Q, hi<=final R same edge, -> DONE.
// - Latency: HI/LO valid WIDTH edges after the start edge (32 for default); div_done high in DONE.
// - Arithmetic: R held in WIDTH+1 bits for compare/subtract; unsigned only; no overflow possible.
// - Divisor 0: no special path; algorithm yields lo=all-ones, hi=dividend, same latency.
// - stall (combinational) = busy & ex_valid & (ex_op==SEL_MFHI | ex_op==SEL_MFLO | ex_op==SEL_DIVU).
//   ex_op==SEL_ALU never stalls; ALU ops overlap the divide. No stall in DONE (HI/LO already new).
// - res_sel = ex_op when ex_valid & ~stall, else SEL_ALU. hi/lo outputs are the registers directly,
//   so MFHI/MFLO in the DONE cycle read the new values.
// - DIVU arriving during DONE starts immediately (DONE->RUN); HI/LO keep the previous result until
//   the new divide finishes.
// - busy=1 exactly in RUN; div_done=1 exactly in DONE.
// TESTING
// - DIVU 100/7 in IDLE -> busy 32 cycles, div_done pulse, lo=14, hi=2.
// - DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, same latency.
// - MFHI held in EX 3 cycles after DIVU 9/4 -> stall high until DONE, res_sel=2'b10, hi=1 read.
// - ALU ops each cycle during RUN -> stall stays 0, res_sel=2'b11, result unaffected.
// - DIVU 10/3 then DIVU 20/6 in EX behind it -> second stalls, starts in DONE; lo=3,hi=1 then lo=3,hi=2.
// - rst_n low at step 15 of 100/7 -> hi=lo=0, IDLE, busy=0 asynchronously; next DIVU runs normally.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// HI/LO owner and multicycle DIVU sequencer for the 5-stage core.
// Restoring division, one quotient bit per clock, EX-stage hazard stall.
module hilo_div_ctrl #(
  parameter int         WIDTH    = 32,
  parameter logic [1:0] SEL_DIVU = 2'b00,
  parameter logic [1:0] SEL_MFLO = 2'b01,
  parameter logic [1:0] SEL_MFHI = 2'b10,
  parameter logic [1:0] SEL_ALU  = 2'b11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ex_op,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       res_sel,
  output logic             stall,
  output logic             busy,
  output logic             div_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic             fit;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;
  logic             hazard;
  logic             start;

  // One restoring step: R needs the extra bit only for the compare.
  always_comb begin
    r_sh = {r, q[WIDTH-1]};
    diff = r_sh - {1'b0, dvs};
    fit  = (r_sh >= {1'b0, dvs});
    r_nx = fit ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    q_nx = {q[WIDTH-2:0], fit};
  end

  assign busy     = (state == RUN);
  assign div_done = (state == DONE);

  assign hazard = (ex_op == SEL_MFHI) | (ex_op == SEL_MFLO) |
                  (ex_op == SEL_DIVU);
  assign stall  = busy & ex_valid & hazard;
  assign start  = ex_valid & (ex_op == SEL_DIVU) & ~stall;

  assign res_sel = (ex_valid & ~stall) ? ex_op : SEL_ALU;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      dvs   <= '0;
      q     <= '0;
      r     <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        RUN: begin
          q     <= q_nx;
          r     <= r_nx;
          count <= count + 1'b1;
          if (count == LAST) begin
            lo    <= q_nx;
            hi    <= r_nx;
            state <= DONE;
          end
        end
        IDLE, DONE: begin
          if (start) begin
            dvs   <= divisor;
            q     <= dividend;
            r     <= '0;
            count <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Scoreboard bench for hilo_div_ctrl: expected HI/LO queued at DIVU
// issue, popped and compared on each div_done pulse.
module tb_hilo_div_ctrl;

  localparam int W = 32;
  localparam logic [1:0] DIVU = 2'b00;
  localparam logic [1:0] MFLO = 2'b01;
  localparam logic [1:0] MFHI = 2'b10;
  localparam logic [1:0] ALU  = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   ex_op = ALU;
  logic         ex_valid = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] hi, lo;
  logic [1:0]   res_sel;
  logic         stall, busy, div_done;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;
  res_t sb[$];

  hilo_div_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_op(ex_op), .ex_valid(ex_valid),
    .dividend(dividend), .divisor(divisor), .hi(hi), .lo(lo),
    .res_sel(res_sel), .stall(stall), .busy(busy),
    .div_done(div_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    res_t e;
    if (b == 0) begin
      e.lo = '1;
      e.hi = a;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Present DIVU in EX, hold through any stall, release after acceptance.
  task automatic divu(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    ex_valid = 1'b1;
    ex_op    = DIVU;
    dividend = a;
    divisor  = b;
    #1;
    n = 0;
    while (stall && n < 100) begin
      step();
      #1;
      n++;
    end
    if (n >= 100) chk("divu_stall_timeout", 1, 0);
    sb.push_back(model(a, b));
    step();
    ex_valid = 1'b0;
    ex_op    = ALU;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || div_done) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  // Monitor: compare results on div_done and check RUN length.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else if (div_done) begin
      chk("run_cycles", busy_cnt, 32);
      busy_cnt = 0;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("lo", lo, e.lo);
        chk("hi", hi, e.hi);
      end
    end else if (busy) begin
      busy_cnt++;
    end
  end

  initial begin
    int n;
    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", div_done, 0);
    chk("rst_sel", res_sel, ALU);
    rst_n = 1'b1;
    step();

    divu(100, 7);
    chk("busy_after_start", busy, 1);
    wait_idle();
    chk("lo_100_7", lo, 14);
    chk("hi_100_7", hi, 2);

    divu(32'hFFFF_FFFF, 1);
    wait_idle();
    divu(5, 0);
    wait_idle();
    chk("lo_div0", lo, 32'hFFFF_FFFF);
    chk("hi_div0", hi, 5);

    // MFHI behind DIVU 9/4 stalls until DONE
    divu(9, 4);
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1;
      ex_op    = ALU;
      #1;
      chk("alu_gap_stall", stall, 0);
      step();
    end
    ex_op = MFHI;
    #1;
    chk("mfhi_stall", stall, 1);
    chk("mfhi_sel_stalled", res_sel, ALU);
    n = 0;
    while (stall && n < 100) begin
      step();
      #1;
      n++;
    end
    chk("mfhi_in_done", div_done, 1);
    chk("mfhi_sel", res_sel, MFHI);
    chk("mfhi_hi", hi, 1);
    step();
    ex_valid = 1'b0;
    ex_op    = ALU;
    wait_idle();

    // ALU ops overlap a divide without stalling
    divu(1000, 10);
    for (int i = 0; i < 10; i++) begin
      ex_valid = 1'b1;
      ex_op    = ALU;
      #1;
      chk("alu_no_stall", stall, 0);
      chk("alu_sel", res_sel, ALU);
      step();
    end
    ex_valid = 1'b0;
    wait_idle();

    // Back-to-back DIVU: second one starts from DONE
    divu(10, 3);
    divu(20, 6);
    chk("b2b_busy", busy, 1);
    chk("b2b_old_lo", lo, 3);
    chk("b2b_old_hi", hi, 1);
    wait_idle();
    chk("b2b_lo", lo, 3);
    chk("b2b_hi", hi, 2);

    // Async reset mid-division
    divu(100, 7);
    repeat (15) step();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_busy", busy, 0);
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    divu(50, 8);
    wait_idle();
    chk("post_rst_lo", lo, 6);
    chk("post_rst_hi", hi, 2);

    step();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
